id_pipe: RTL

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/id_pipe.sv
// id_pipe: decode stage; reads operands, resolves branches/jumps, interlocks load-use and branch-operand hazards.
// Latency: one cycle from acceptance to out_valid; sustains one instruction per cycle.
// Backpressure: the output bundle holds while out_ready is low; in_ready drops on stall, hazard or HALT.
// Optional: define ID_WB_BYPASS_EN to forward the writeback port onto the rs/rt operand values.

`ifndef EXE_NOP_OP
`define EXE_NOP_OP 8'h00
`define EXE_ADD_OP 8'h01
`define EXE_SUB_OP 8'h02
`define EXE_AND_OP 8'h03
`define EXE_OR_OP  8'h04
`define EXE_XOR_OP 8'h05
`define EXE_SLL_OP 8'h06
`define EXE_SRL_OP 8'h07
`define EXE_SRA_OP 8'h08
`endif

module id_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [31:0]        in_pc,
  output logic [REG_AW-1:0]  rs_addr,
  output logic [REG_AW-1:0]  rt_addr,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic               wb_we,
  input  logic [REG_AW-1:0]  wb_waddr,
  input  logic [DATA_W-1:0]  wb_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] aluop,
  output logic [DATA_W-1:0]  op1,
  output logic [DATA_W-1:0]  op2,
  output logic [DATA_W-1:0]  store_data,
  output logic [REG_AW-1:0]  waddr,
  output logic               wreg,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               halted,
  input  logic               flush,
  input  logic               restart
);

  typedef enum logic [1:0] {ST_RUN, ST_KILL, ST_HALT} state_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_HALT = 6'b111111;
  localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL = 6'b000010, FN_SRA = 6'b000011, FN_JR = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_XOR = 6'b100110;

  state_t state, state_nxt;

  logic [5:0]        opcode, funct;
  logic [15:0]       imm;
  logic [REG_AW-1:0] rd_addr;
  logic [DATA_W-1:0] rs_val, rt_val, imm_sx, imm_zx, shamt_zx;
  logic [31:0]       pc4, br_tgt, j_tgt;

  assign opcode   = in_inst[31:26];
  assign funct    = in_inst[5:0];
  assign imm      = in_inst[15:0];
  assign rs_addr  = REG_AW'(in_inst[25:21]);
  assign rt_addr  = REG_AW'(in_inst[20:16]);
  assign rd_addr  = REG_AW'(in_inst[15:11]);
  assign imm_sx   = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zx   = {{(DATA_W-16){1'b0}}, imm};
  assign shamt_zx = {{(DATA_W-5){1'b0}}, in_inst[10:6]};
  assign pc4      = in_pc + 32'd4;
  assign br_tgt   = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_tgt    = {pc4[31:28], in_inst[25:0], 2'b00};

`ifdef ID_WB_BYPASS_EN
  assign rs_val = (wb_we && wb_waddr == rs_addr && rs_addr != '0) ? wb_wdata : rs_data;
  assign rt_val = (wb_we && wb_waddr == rt_addr && rt_addr != '0) ? wb_wdata : rt_data;
`else
  logic unused_wb;
  assign rs_val    = rs_data;
  assign rt_val    = rt_data;
  assign unused_wb = ^{wb_we, wb_waddr, wb_wdata};
`endif

  logic [ALUOP_W-1:0] d_aluop;
  logic [DATA_W-1:0]  d_op1, d_op2, d_store;
  logic [REG_AW-1:0]  d_waddr;
  logic               d_wen, d_rd, d_wr, use_rs, use_rt, is_ctrl, taken, is_halt;
  logic [31:0]        tgt;

  // Decode the incoming instruction into an EX bundle plus control-flow resolution.
  always_comb begin
    d_aluop = ALUOP_W'(`EXE_NOP_OP);
    d_op1 = '0; d_op2 = '0; d_store = '0;
    d_waddr = rd_addr; d_wen = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    use_rs = 1'b0; use_rt = 1'b0; is_ctrl = 1'b0; taken = 1'b0; is_halt = 1'b0;
    tgt = pc4;
    case (opcode)
      OP_ADDI: begin d_aluop = ALUOP_W'(`EXE_ADD_OP); d_op1 = rs_val; d_op2 = imm_sx;
                     d_waddr = rt_addr; d_wen = 1'b1; use_rs = 1'b1; end
      OP_ANDI: begin d_aluop = ALUOP_W'(`EXE_AND_OP); d_op1 = rs_val; d_op2 = imm_zx;
                     d_waddr = rt_addr; d_wen = 1'b1; use_rs = 1'b1; end
      OP_ORI:  begin d_aluop = ALUOP_W'(`EXE_OR_OP); d_op1 = rs_val; d_op2 = imm_zx;
                     d_waddr = rt_addr; d_wen = 1'b1; use_rs = 1'b1; end
      OP_XORI: begin d_aluop = ALUOP_W'(`EXE_XOR_OP); d_op1 = rs_val; d_op2 = imm_zx;
                     d_waddr = rt_addr; d_wen = 1'b1; use_rs = 1'b1; end
      OP_LUI:  begin d_aluop = ALUOP_W'(`EXE_OR_OP); d_op1 = DATA_W'({imm, 16'h0000});
                     d_waddr = rt_addr; d_wen = 1'b1; end
      OP_LW:   begin d_aluop = ALUOP_W'(`EXE_ADD_OP); d_op1 = rs_val; d_op2 = imm_sx;
                     d_waddr = rt_addr; d_wen = 1'b1; d_rd = 1'b1; use_rs = 1'b1; end
      OP_SW:   begin d_aluop = ALUOP_W'(`EXE_ADD_OP); d_op1 = rs_val; d_op2 = imm_sx;
                     d_store = rt_val; d_wr = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_BEQ:  begin use_rs = 1'b1; use_rt = 1'b1; is_ctrl = 1'b1;
                     taken = (rs_val == rt_val); tgt = br_tgt; end
      OP_BNE:  begin use_rs = 1'b1; use_rt = 1'b1; is_ctrl = 1'b1;
                     taken = (rs_val != rt_val); tgt = br_tgt; end
      OP_J:    begin taken = 1'b1; tgt = j_tgt; end
      OP_JAL:  begin d_aluop = ALUOP_W'(`EXE_ADD_OP); d_op1 = DATA_W'(pc4);
                     d_waddr = REG_AW'(31); d_wen = 1'b1; taken = 1'b1; tgt = j_tgt; end
      OP_HALT: is_halt = 1'b1;
      OP_SPECIAL: begin
        case (funct)
          FN_SLL: begin d_aluop = ALUOP_W'(`EXE_SLL_OP); d_op1 = shamt_zx; d_op2 = rt_val;
                        d_wen = 1'b1; use_rt = 1'b1; end
          FN_SRL: begin d_aluop = ALUOP_W'(`EXE_SRL_OP); d_op1 = shamt_zx; d_op2 = rt_val;
                        d_wen = 1'b1; use_rt = 1'b1; end
          FN_SRA: begin d_aluop = ALUOP_W'(`EXE_SRA_OP); d_op1 = shamt_zx; d_op2 = rt_val;
                        d_wen = 1'b1; use_rt = 1'b1; end
          FN_JR:  begin use_rs = 1'b1; is_ctrl = 1'b1; taken = 1'b1; tgt = rs_val[31:0]; end
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: begin
            d_op1 = rs_val; d_op2 = rt_val; d_wen = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
            case (funct)
              FN_ADD:  d_aluop = ALUOP_W'(`EXE_ADD_OP);
              FN_SUB:  d_aluop = ALUOP_W'(`EXE_SUB_OP);
              FN_AND:  d_aluop = ALUOP_W'(`EXE_AND_OP);
              FN_OR:   d_aluop = ALUOP_W'(`EXE_OR_OP);
              default: d_aluop = ALUOP_W'(`EXE_XOR_OP);
            endcase
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Shadow of the instruction that left the output register last cycle (its result is not yet readable).
  logic              sh_vld, sh_load;
  logic [REG_AW-1:0] sh_waddr;
  logic              hz_rs, hz_rt, hazard;

  assign hz_rs = use_rs && rs_addr != '0 &&
                 ((out_valid && wreg && (mem_rd || is_ctrl) && waddr == rs_addr) ||
                  (sh_vld && (sh_load || is_ctrl) && sh_waddr == rs_addr));
  assign hz_rt = use_rt && rt_addr != '0 &&
                 ((out_valid && wreg && (mem_rd || is_ctrl) && waddr == rt_addr) ||
                  (sh_vld && (sh_load || is_ctrl) && sh_waddr == rt_addr));
  assign hazard = hz_rs || hz_rt;

  logic accept, issue;

  // Handshake outputs and RUN/KILL/HALT next-state; flush only leaves KILL, never HALT.
  always_comb begin
    in_ready    = (state != ST_HALT) && (!out_valid || out_ready) && !hazard;
    accept      = in_valid && in_ready;
    issue       = accept && (state == ST_RUN) && !is_halt && !flush;
    redirect    = rst && accept && (state == ST_RUN) && taken && !flush;
    redirect_pc = tgt;
    halted      = (state == ST_HALT);
    state_nxt   = state;
    if (flush) begin
      if (state == ST_KILL) state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept && taken)        state_nxt = ST_KILL;
          else if (accept && is_halt) state_nxt = ST_HALT;
        end
        ST_KILL: if (accept)  state_nxt = ST_RUN;
        ST_HALT: if (restart) state_nxt = ST_RUN;
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // Output register and load shadow; bundle only changes when a new instruction issues.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0; aluop <= ALUOP_W'(`EXE_NOP_OP);
      op1 <= '0; op2 <= '0; store_data <= '0; waddr <= '0;
      wreg <= 1'b0; mem_rd <= 1'b0; mem_wr <= 1'b0;
      sh_vld <= 1'b0; sh_load <= 1'b0; sh_waddr <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sh_vld    <= 1'b0;
    end else begin
      sh_vld   <= out_valid && out_ready && wreg;
      sh_load  <= mem_rd;
      sh_waddr <= waddr;
      if (issue) begin
        out_valid  <= 1'b1;
        aluop      <= d_aluop;
        op1        <= d_op1;
        op2        <= d_op2;
        store_data <= d_store;
        waddr      <= d_waddr;
        wreg       <= d_wen && (d_waddr != '0);
        mem_rd     <= d_rd;
        mem_wr     <= d_wr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
